ex_operand_stage: RTL

ID/EX pipeline register plus EX-side operand selection for the RV32 pipeline. Captures decoded ID instructions and exports the EX source addresses to the forwarding unit. Applies its forwardA/forwardB selects to build ALU operands and store data, and runs the load-use interlock, which stalls IF/ID and injects a bubble.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/operand_fwd_mux.sv | 27 ++
 rtl/ex_operand_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types for the ID/EX operand stage
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_H   = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       use_pc;
        logic       use_imm;
        logic       rd_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic [3:0] alu_op;
    } ex_ctrl_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - 4:1 operand forwarding mux
module operand_fwd_mux
    import ex_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] rf_data,
    input  logic [W-1:0] mem_data,
    input  logic [W-1:0] wb_data,
    input  logic [W-1:0] h_data,
    output logic [W-1:0] data
);

    // Pick the freshest copy of the source register named by the forwarding unit
    always_comb begin
        data = rf_data;
        case (fwd_sel_e'(sel))
            FWD_RF:  data = rf_data;
            FWD_WB:  data = wb_data;
            FWD_MEM: data = mem_data;
            FWD_H:   data = h_data;
            default: data = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register, operand forwarding and load-use interlock
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int XLEN  = ex_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [4:0]       id_rd_i,
    input  ex_ctrl_t         id_ctrl_i,
    input  logic             flush_i,
    input  logic [1:0]       forwardA,
    input  logic [1:0]       forwardB,
    input  logic [XLEN-1:0]  mem_fwd_data_i,
    input  logic [XLEN-1:0]  wb_fwd_data_i,
    input  logic [XLEN-1:0]  h_fwd_data_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_o,
    output ex_ctrl_t         ex_ctrl_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_valid_q;
    logic [XLEN-1:0]  ex_pc_q;
    logic [4:0]       ex_rs1_addr_q;
    logic [4:0]       ex_rs2_addr_q;
    logic [XLEN-1:0]  ex_rs1_data_q;
    logic [XLEN-1:0]  ex_rs2_data_q;
    logic [XLEN-1:0]  ex_imm_q;
    logic [4:0]       ex_rd_q;
    ex_ctrl_t         ex_ctrl_q;
    state_e           state_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             hz;
    logic             rs1_match;
    logic             rs2_match;
    logic [XLEN-1:0]  fwd_a;
    logic [XLEN-1:0]  fwd_b;

    // Load in EX whose destination is read by the real instruction in ID
    always_comb begin
        rs1_match = id_rs1_used_i && (id_rs1_addr_i == ex_rd_q);
        rs2_match = id_rs2_used_i && (id_rs2_addr_i == ex_rd_q);
        hz        = ex_valid_q && ex_ctrl_q.mem_rd && (ex_rd_q != 5'd0)
                    && (rs1_match || rs2_match) && id_valid_i;
        stall_o   = rst_n && hz && !flush_i && (state_q == RUN);
    end

    // ID/EX register: flush or stall inserts a bubble, otherwise capture ID
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i || stall_o) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_addr_q <= '0;
            ex_rs2_addr_q <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
        end else begin
            ex_valid_q    <= id_valid_i;
            ex_pc_q       <= id_pc_i;
            ex_rs1_addr_q <= id_rs1_used_i ? id_rs1_addr_i : 5'd0;
            ex_rs2_addr_q <= id_rs2_used_i ? id_rs2_addr_i : 5'd0;
            ex_rs1_data_q <= id_rs1_data_i;
            ex_rs2_data_q <= id_rs2_data_i;
            ex_imm_q      <= id_imm_i;
            ex_rd_q       <= id_rd_i;
            ex_ctrl_q     <= id_ctrl_i;
        end
    end

    // Interlock FSM: one stall cycle, then one cycle in which no stall may be raised
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     state_q <= stall_o ? BUBBLE : RUN;
                BUBBLE:  state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    operand_fwd_mux #(.W(XLEN)) u_fwd_a (
        .sel      (forwardA),
        .rf_data  (ex_rs1_data_q),
        .mem_data (mem_fwd_data_i),
        .wb_data  (wb_fwd_data_i),
        .h_data   (h_fwd_data_i),
        .data     (fwd_a)
    );

    operand_fwd_mux #(.W(XLEN)) u_fwd_b (
        .sel      (forwardB),
        .rf_data  (ex_rs2_data_q),
        .mem_data (mem_fwd_data_i),
        .wb_data  (wb_fwd_data_i),
        .h_data   (h_fwd_data_i),
        .data     (fwd_b)
    );

    // ALU operand and store data selection, held at zero while in reset
    always_comb begin
        alu_a_o      = '0;
        alu_b_o      = '0;
        store_data_o = '0;
        if (rst_n) begin
            alu_a_o      = ex_ctrl_q.use_pc  ? ex_pc_q  : fwd_a;
            alu_b_o      = ex_ctrl_q.use_imm ? ex_imm_q : fwd_b;
            store_data_o = fwd_b;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_rs1_addr_o = ex_rs1_addr_q;
    assign ex_rs2_addr_o = ex_rs2_addr_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule
